slow_tick_bcd_counter: RTL and testbench
========================================

Name: slow_tick_bcd_counter

Overview:
- Directly downstream of the slow clock divider. Consumes the divider's slow square wave as data, not as a clock.
- Resynchronises the slow wave into the CLK domain and edge-detects it into a one-cycle tick.
- Steps a run/pause-controlled, up/down, multi-digit BCD counter on each tick.
- Feeds the seven-segment display stage.

Parameters:
- DIGITS, 4: number of BCD digits; count width is 4*DIGITS.
- SYNC_STAGES, 2: flops in the slowClk synchroniser chain; legal values are 2 or more.

Ports:
- CLK  input  1  system clock (fast clock).
- RST_N  input  1  asynchronous active-low reset.
- slow_clk_in  input  1  slow square wave from the clock divider; asynchronous to this block's logic.
- start  input  1  pulse or level: enter RUN.
- stop  input  1  pulse or level: enter PAUSE.
- clear  input  1  zero the count and return to IDLE.
- load  input  1  load load_val (honoured only in IDLE or PAUSE).
- load_val  input  4*DIGITS  BCD preset value.
- up  input  1  1 = count up, 0 = count down.
- count  output  4*DIGITS  current BCD count.
- tick  output  1  one-cycle pulse per slow_clk_in rising edge.
- carry  output  1  one-cycle pulse on wrap (or on saturation).
- running  output  1  high while in RUN.

Behaviour:
- **Reset** (RST_N low, asynchronous): sync chain, edge-detect flop, count, tick, carry and running all go to 0; state goes to IDLE.
- **Synchroniser:** slow_clk_in passes through SYNC_STAGES flops, then one previous-value flop.
  - tick is registered high for exactly one CLK cycle when the last sync stage is 1 and the previous-value flop is 0.
  - Latency with SYNC_STAGES=2: tick is high in the 3rd cycle after the first CLK edge that samples slow_clk_in high.
  - A falling edge produces no tick. A high level held indefinitely produces exactly one tick.
- **State machine** (2-bit state: IDLE=0, RUN=1, PAUSE=2):
  - IDLE: start moves to RUN.
  - RUN: stop moves to PAUSE.
  - PAUSE: start moves to RUN.
  - Any state: clear moves to IDLE.
  - start and stop together: stop wins (RUN goes to PAUSE; IDLE and PAUSE stay put).
  - running = (state == RUN).
- **Command priority** per cycle: clear > load > step.
  - clear: count becomes 0. This includes RUN with a coincident tick.
  - load in IDLE or PAUSE: count = load_val. Any load_val nibble greater than 9 is clamped to 9 per digit.
  - load in RUN: ignored.
- **Step:** occurs only in RUN, on a cycle where the registered edge-detect fires. count updates on the same CLK edge that raises tick, so the new count and tick are visible in the same cycle.
  - Up: least-significant digit +1. A digit at 9 goes to 0 and carries into the next digit.
  - Down: least-significant digit -1. A digit at 0 goes to 9 and borrows from the next digit.
- **Wrap:**
  - Up from all-9s (9999 for DIGITS=4) gives 0000 and carry=1 for one cycle.
  - Down from 0000 gives 9999 and carry=1 for one cycle.
- **Ignored ticks:** ticks arriving in IDLE or PAUSE still pulse tick but leave count unchanged.
- **Direction change:** up is sampled on the step cycle. Changing up mid-run takes effect on the next tick.
- **Reset mid-operation:** asynchronous clear of everything. The first slow_clk_in rising edge after reset release produces a tick. If slow_clk_in is already high at release, the sync chain sees 0→1, so one tick is produced.
- **Carry:** 0 on every cycle except the wrap or saturation cycle.

Optional Feature:
- Macro: SLOW_TICK_BCD_SAT_EN.
- Defined (saturating mode):
  - Up at all-9s holds the count at all-9s.
  - Down at 0000 holds the count at 0000.
  - On that step, carry pulses once and the FSM moves RUN→PAUSE automatically, so later ticks do not pulse carry again.
- Not defined: wrap-around as described in Behaviour, and no automatic pause.

Test Plan:
- Reset, then 3 slow_clk_in periods while in IDLE → tick pulses 3 times, each exactly 1 CLK wide; count stays 0000; running=0.
- start, up=1, 12 slow rising edges → count=0012. Each change lands in the same cycle as tick, 3 CLK after the sampled rise.
- In PAUSE, load with load_val=0x9998, then start, then 3 ticks up → counts 9999, 0000 (carry=1 that cycle only), 0001. With SLOW_TICK_BCD_SAT_EN defined: 9999, 9999 (carry=1, running drops to 0), 9999.
- From 0000 in RUN, up=0, 2 ticks → 9999 with carry pulse, then 9998.
- Simultaneous start+stop in RUN → PAUSE. clear coincident with a tick in RUN → count=0000 and state=IDLE. load of 0xAF3C while in PAUSE → count=0x9939.
- Assert RST_N low mid-count at 0457 with slow_clk_in held high → all outputs 0 asynchronously. After release, exactly one tick occurs and count stays 0000 (IDLE).

Source files
------------

// File: rtl/slow_tick_bcd_counter.sv
// Resynchronises the divider's slow square wave into a one-cycle tick and steps a
// run/pause, up/down BCD counter on it. Define SLOW_TICK_BCD_SAT_EN for saturating mode.
module slow_tick_bcd_counter #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  slow_clk_in,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  up,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tick,
    output logic                  carry,
    output logic                  running
);

    localparam int unsigned CW = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   edge_c;
    logic [CW-1:0]          count_d;
    logic                   carry_d;
    logic [CW-1:0]          step_val;
    logic [CW-1:0]          clamp_val;
    logic                   wrap;
    logic                   ripple;
    logic [3:0]             digit;
    logic [3:0]             ld_digit;

    assign edge_c = sync_q[SYNC_STAGES-1] & ~prev_q;

    // Ripple +1/-1 through the BCD digits; ripple surviving the top digit means wrap.
    always_comb begin
        step_val = count;
        ripple   = 1'b1;
        digit    = 4'd0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            digit = count[4*i +: 4];
            if (ripple) begin
                if (up) begin
                    ripple             = (digit == 4'd9);
                    step_val[4*i +: 4] = ripple ? 4'd0 : digit + 4'd1;
                end else begin
                    ripple             = (digit == 4'd0);
                    step_val[4*i +: 4] = ripple ? 4'd9 : digit - 4'd1;
                end
            end
        end
        wrap = ripple;
    end

    // Preset value with each non-BCD nibble clamped to 9.
    always_comb begin
        clamp_val = load_val;
        ld_digit  = 4'd0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            ld_digit = load_val[4*i +: 4];
            if (ld_digit > 4'd9) begin
                clamp_val[4*i +: 4] = 4'd9;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count;
        carry_d = 1'b0;

        unique case (state_q)
            IDLE:    if (start && !stop) state_d = RUN;
            RUN:     if (stop)           state_d = PAUSE;
            PAUSE:   if (start && !stop) state_d = RUN;
            default:                     state_d = IDLE;
        endcase

        if (clear) begin
            state_d = IDLE;
            count_d = '0;
        end else if (load && (state_q != RUN)) begin
            count_d = clamp_val;
        end else if (edge_c && (state_q == RUN)) begin
`ifdef SLOW_TICK_BCD_SAT_EN
            if (wrap) begin
                carry_d = 1'b1;
                state_d = PAUSE;
            end else begin
                count_d = step_val;
            end
`else
            count_d = step_val;
            carry_d = wrap;
`endif
        end
    end

    // running is taken from the next state so it always equals (state == RUN).
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            sync_q  <= '0;
            prev_q  <= 1'b0;
            count   <= '0;
            tick    <= 1'b0;
            carry   <= 1'b0;
            running <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[SYNC_STAGES-2:0], slow_clk_in};
            prev_q  <= sync_q[SYNC_STAGES-1];
            count   <= count_d;
            tick    <= edge_c;
            carry   <= carry_d;
            running <= (state_d == RUN);
        end
    end

endmodule

// File: tb/tb_slow_tick_bcd_counter.sv
// Directed bench for slow_tick_bcd_counter; expectations follow SLOW_TICK_BCD_SAT_EN when defined.
module tb_slow_tick_bcd_counter;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        slow;
    logic        start, stop, clear, load, up;
    logic [15:0] load_val;
    logic [15:0] count;
    logic        tick, carry, running;

    int total  = 0;
    int failed = 0;

    slow_tick_bcd_counter #(.DIGITS(4), .SYNC_STAGES(2)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .slow_clk_in(slow),
        .start      (start),
        .stop       (stop),
        .clear      (clear),
        .load       (load),
        .load_val   (load_val),
        .up         (up),
        .count      (count),
        .tick       (tick),
        .carry      (carry),
        .running    (running)
    );

    always #5 CLK = ~CLK;

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [15:0] bcd(input int n);
        return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
    endfunction

    // One slow period: tick must rise on the 3rd edge after the sampled rise, for one cycle.
    task automatic slow_pulse(input string tag, input logic [15:0] exp_cnt,
                              input logic exp_carry, input logic exp_run);
        slow = 1'b1;
        cyc();
        cyc();
        chk({tag, "_tick_early"}, 16'(tick), 16'd0);
        cyc();
        chk({tag, "_tick"}, 16'(tick), 16'd1);
        chk({tag, "_count"}, count, exp_cnt);
        chk({tag, "_carry"}, 16'(carry), 16'(exp_carry));
        chk({tag, "_running"}, 16'(running), 16'(exp_run));
        cyc();
        chk({tag, "_tick_off"}, 16'(tick), 16'd0);
        chk({tag, "_carry_off"}, 16'(carry), 16'd0);
        slow = 1'b0;
        repeat (3) cyc();
    endtask

    int nticks;

    initial begin
        RST_N = 1'b0; slow = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
        load = 1'b0; up = 1'b1; load_val = 16'h0000;
        repeat (3) cyc();
        chk("rst_count", count, 16'h0000);
        chk("rst_tick", 16'(tick), 16'd0);
        chk("rst_carry", 16'(carry), 16'd0);
        chk("rst_running", 16'(running), 16'd0);
        RST_N = 1'b1;
        repeat (3) cyc();

        for (int i = 0; i < 3; i++) slow_pulse($sformatf("idle%0d", i), 16'h0000, 1'b0, 1'b0);

        start = 1'b1; cyc(); start = 1'b0;
        chk("start_running", 16'(running), 16'd1);
        for (int i = 1; i <= 12; i++) slow_pulse($sformatf("up%0d", i), bcd(i), 1'b0, 1'b1);
        chk("up12_count", count, 16'h0012);

        stop = 1'b1; cyc(); stop = 1'b0;
        chk("stop_running", 16'(running), 16'd0);
        load_val = 16'h9998; load = 1'b1; cyc(); load = 1'b0;
        chk("load_9998", count, 16'h9998);
        start = 1'b1; cyc(); start = 1'b0;
`ifdef SLOW_TICK_BCD_SAT_EN
        slow_pulse("wrap_a", 16'h9999, 1'b0, 1'b1);
        slow_pulse("wrap_b", 16'h9999, 1'b1, 1'b0);
        slow_pulse("wrap_c", 16'h9999, 1'b0, 1'b0);
`else
        slow_pulse("wrap_a", 16'h9999, 1'b0, 1'b1);
        slow_pulse("wrap_b", 16'h0000, 1'b1, 1'b1);
        slow_pulse("wrap_c", 16'h0001, 1'b0, 1'b1);
`endif

        clear = 1'b1; cyc(); clear = 1'b0;
        chk("clear_count", count, 16'h0000);
        chk("clear_running", 16'(running), 16'd0);
        start = 1'b1; up = 1'b0; cyc(); start = 1'b0;
`ifdef SLOW_TICK_BCD_SAT_EN
        slow_pulse("down_a", 16'h0000, 1'b1, 1'b0);
        slow_pulse("down_b", 16'h0000, 1'b0, 1'b0);
`else
        slow_pulse("down_a", 16'h9999, 1'b1, 1'b1);
        slow_pulse("down_b", 16'h9998, 1'b0, 1'b1);
`endif

        start = 1'b1; cyc(); start = 1'b0;
        chk("rerun_running", 16'(running), 16'd1);
        start = 1'b1; stop = 1'b1; cyc();
        chk("startstop_run", 16'(running), 16'd0);
        cyc(); start = 1'b0; stop = 1'b0;
        chk("startstop_pause", 16'(running), 16'd0);

        load_val = 16'hAF3C; load = 1'b1; cyc(); load = 1'b0;
        chk("load_clamp", count, 16'h9939);
        start = 1'b1; cyc(); start = 1'b0;
        load_val = 16'h1234; load = 1'b1; cyc(); load = 1'b0;
        chk("load_in_run", count, 16'h9939);
        chk("load_in_run_running", 16'(running), 16'd1);

        slow = 1'b1; cyc(); cyc();
        clear = 1'b1; cyc(); clear = 1'b0;
        chk("clr_tick_tick", 16'(tick), 16'd1);
        chk("clr_tick_count", count, 16'h0000);
        chk("clr_tick_running", 16'(running), 16'd0);
        chk("clr_tick_carry", 16'(carry), 16'd0);
        cyc(); slow = 1'b0; repeat (3) cyc();

        load_val = 16'h0457; load = 1'b1; cyc(); load = 1'b0;
        chk("load_0457", count, 16'h0457);
        start = 1'b1; cyc(); start = 1'b0;
        chk("run_0457", 16'(running), 16'd1);
        slow = 1'b1; cyc();
        RST_N = 1'b0; #1;
        chk("async_count", count, 16'h0000);
        chk("async_tick", 16'(tick), 16'd0);
        chk("async_carry", 16'(carry), 16'd0);
        chk("async_running", 16'(running), 16'd0);
        cyc();
        RST_N = 1'b1;
        nticks = 0;
        for (int i = 1; i <= 12; i++) begin
            cyc();
            if (tick) nticks++;
            if (i == 3) chk("post_rst_tick3", 16'(tick), 16'd1);
        end
        chk("post_rst_ntick", 16'(nticks), 16'd1);
        chk("post_rst_count", count, 16'h0000);
        chk("post_rst_running", 16'(running), 16'd0);

        $display("[TB] %0d tests run, %0d failed", total, failed);
        $finish;
    end

endmodule
